// File: rtl/mips_pkg.sv
// Shared types for the MIPS pipeline hazard logic: the scoreboard slot entry
// and the forward-select encoding that means "take the register file value".
package mips_pkg;

  localparam int REG_AW_DEF = 5;
  localparam int FWD_RF     = 0;

  // One in-flight instruction as seen by the hazard unit.
  typedef struct packed {
    logic                  v;
    logic                  wb;
    logic                  ld;
    logic [REG_AW_DEF-1:0] dest;
  } slot_t;

endpackage

// File: rtl/hazard_match.sv
// Per-source comparator: flags every scoreboard slot that will write the
// register this source reads, and reports the youngest such slot as a
// forward select (1 + slot index, FWD_RF when nothing matches).
module hazard_match
  import mips_pkg::*;
#(
  parameter int STAGES    = 3,
  parameter int WB_BYPASS = 1,
  parameter int SEL_W     = 2
) (
  input  slot_t [STAGES-1:0]     slots,
  input  logic  [REG_AW_DEF-1:0] src,
  input  logic                   src_used,
  output logic  [STAGES-1:0]     match,
  output logic  [SEL_W-1:0]      sel
);

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_cmp
      // The WB slot is invisible when the register file writes before it reads.
      localparam bit EXCLUDED = (gi == STAGES - 1) && (WB_BYPASS != 0);
      // Register 0 is hardwired, so a write to it never creates a dependency.
      assign match[gi] = !EXCLUDED && src_used && slots[gi].v && slots[gi].wb &&
                         (slots[gi].dest != '0) && (slots[gi].dest == src);
    end
  endgenerate

  // Walk oldest to youngest so the youngest match wins.
  always_comb begin
    sel = SEL_W'(FWD_RF);
    for (int k = STAGES - 1; k >= 0; k--) begin
      if (match[k]) sel = SEL_W'(k + 1);
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard unit for the pipelined MIPS core. Tracks pending register writes
// from EXE through WB, stalls decode on RAW hazards and squashes decode on a
// taken branch. Define HAZARD_SCOREBOARD_FORWARDING_EN to stall only on
// load-use and drive operand forward selects instead.
module hazard_scoreboard
  import mips_pkg::*;
#(
  parameter int REG_AW    = REG_AW_DEF,
  parameter int STAGES    = 3,
  parameter int WB_BYPASS = 1,
  parameter int CNT_W     = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        id_valid,
  input  logic [REG_AW-1:0]           id_src1,
  input  logic [REG_AW-1:0]           id_src2,
  input  logic                        id_src2_used,
  input  logic [REG_AW-1:0]           id_dest,
  input  logic                        id_wb_en,
  input  logic                        id_mem_r_en,
  input  logic                        branch_taken,
  output logic                        stall,
  output logic                        flush,
  output logic [$clog2(STAGES+1)-1:0] fwd_sel1,
  output logic [$clog2(STAGES+1)-1:0] fwd_sel2,
  output logic [CNT_W-1:0]            stall_cnt
);

  localparam int SEL_W = $clog2(STAGES + 1);
`ifdef HAZARD_SCOREBOARD_FORWARDING_EN
  localparam bit FWD_ON = 1'b1;
`else
  localparam bit FWD_ON = 1'b0;
`endif

  slot_t [STAGES-1:0] slot_reg;
  logic  [STAGES-1:0] match1;
  logic  [STAGES-1:0] match2;
  logic  [SEL_W-1:0]  sel1;
  logic  [SEL_W-1:0]  sel2;
  logic               load_use;
  logic               raw_any;
  logic               hazard;
  logic               accept;

  hazard_match #(.STAGES(STAGES), .WB_BYPASS(WB_BYPASS), .SEL_W(SEL_W)) u_match1 (
    .slots    (slot_reg),
    .src      (id_src1),
    .src_used (1'b1),
    .match    (match1),
    .sel      (sel1)
  );

  hazard_match #(.STAGES(STAGES), .WB_BYPASS(WB_BYPASS), .SEL_W(SEL_W)) u_match2 (
    .slots    (slot_reg),
    .src      (id_src2),
    .src_used (id_src2_used),
    .match    (match2),
    .sel      (sel2)
  );

  // Decode-side hazard resolution; branch squash beats stall, and nothing
  // asserts while reset is held.
  always_comb begin
    load_use = slot_reg[0].ld && (match1[0] || match2[0]);
    raw_any  = |{match1, match2};
    hazard   = FWD_ON ? load_use : raw_any;
    stall    = rst && id_valid && hazard && !branch_taken;
    flush    = rst && branch_taken;
    accept   = id_valid && !stall && !branch_taken;
    fwd_sel1 = (FWD_ON && rst) ? sel1 : SEL_W'(FWD_RF);
    fwd_sel2 = (FWD_ON && rst) ? sel2 : SEL_W'(FWD_RF);
  end

  // EXE slot: the accepted decode instruction, or a bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_reg[0] <= '0;
    end else if (accept) begin
      slot_reg[0] <= '{v: 1'b1, wb: id_wb_en, ld: id_mem_r_en, dest: id_dest};
    end else begin
      slot_reg[0] <= '0;
    end
  end

  genvar gi;
  generate
    for (gi = 1; gi < STAGES; gi++) begin : g_shift
      // Downstream stages never stall, so every slot advances each cycle.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) slot_reg[gi] <= '0;
        else      slot_reg[gi] <= slot_reg[gi-1];
      end
    end
  endgenerate

  // Saturating count of cycles spent stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard (STAGES=3, WB_BYPASS=1, CNT_W=4).
// Expectations follow whichever build is compiled: full-stall by default,
// forwarding when HAZARD_SCOREBOARD_FORWARDING_EN is defined.
module tb_hazard_scoreboard;

`ifdef HAZARD_SCOREBOARD_FORWARDING_EN
  localparam bit FWD = 1'b1;
  localparam int SPS = 1;  // stall cycles per load-use pair
`else
  localparam bit FWD = 1'b0;
  localparam int SPS = 2;
`endif

  logic       clk;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_src1;
  logic [4:0] id_src2;
  logic       id_src2_used;
  logic [4:0] id_dest;
  logic       id_wb_en;
  logic       id_mem_r_en;
  logic       branch_taken;
  logic       stall;
  logic       flush;
  logic [1:0] fwd_sel1;
  logic [1:0] fwd_sel2;
  logic [3:0] stall_cnt;

  int total = 0;
  int bad   = 0;

  hazard_scoreboard #(.REG_AW(5), .STAGES(3), .WB_BYPASS(1), .CNT_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_src1      (id_src1),
    .id_src2      (id_src2),
    .id_src2_used (id_src2_used),
    .id_dest      (id_dest),
    .id_wb_en     (id_wb_en),
    .id_mem_r_en  (id_mem_r_en),
    .branch_taken (branch_taken),
    .stall        (stall),
    .flush        (flush),
    .fwd_sel1     (fwd_sel1),
    .fwd_sel2     (fwd_sel2),
    .stall_cnt    (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input int s1, input int s2, input logic s2u,
                       input int d, input logic wb, input logic ld, input logic br);
    id_valid     = v;
    id_src1      = 5'(s1);
    id_src2      = 5'(s2);
    id_src2_used = s2u;
    id_dest      = 5'(d);
    id_wb_en     = wb;
    id_mem_r_en  = ld;
    branch_taken = br;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    drive(1, 3, 3, 1, 3, 1, 1, 1);
    step(); step();
    #1;
    chk("rst_stall", stall, 0);
    chk("rst_flush", flush, 0);
    chk("rst_fwd1", fwd_sel1, 0);
    chk("rst_fwd2", fwd_sel2, 0);
    chk("rst_cnt", stall_cnt, 0);
    rst = 1'b1;
    // Slots must be empty after release: a reader of r3 sees no hazard.
    drive(1, 3, 3, 1, 9, 0, 0, 0);
    #1;
    chk("post_rst_stall", stall, 0);
    chk("post_rst_fwd1", fwd_sel1, 0);
    step();

    // add r3,r1,r2 then sub r4,r3,r1
    drive(1, 1, 2, 1, 3, 1, 0, 0);
    #1; chk("add_r3_stall", stall, 0);
    step();
    drive(1, 3, 1, 1, 4, 1, 0, 0);
    #1;
    chk("raw_c1_stall", stall, FWD ? 0 : 1);
    chk("raw_c1_fwd1", fwd_sel1, FWD ? 1 : 0);
    step();
    #1;
    chk("raw_c2_stall", stall, FWD ? 0 : 1);
    chk("raw_c2_fwd1", fwd_sel1, FWD ? 2 : 0);
    step();
    #1;
    chk("raw_c3_stall", stall, 0);
    chk("raw_c3_fwd1", fwd_sel1, 0);
    chk("raw_cnt", stall_cnt, FWD ? 0 : 2);
    step();

    // r0 dependency never matches
    drive(1, 1, 2, 1, 0, 1, 0, 0);
    step();
    drive(1, 0, 0, 1, 9, 0, 0, 0);
    #1;
    chk("r0_stall", stall, 0);
    chk("r0_fwd1", fwd_sel1, 0);
    chk("r0_fwd2", fwd_sel2, 0);
    step();

    // Branch while a load-use hazard on r5 is present; squashed insn writes r6
    drive(1, 1, 2, 1, 5, 1, 1, 0);
    step();
    drive(1, 5, 0, 0, 6, 1, 1, 1);
    #1;
    chk("br_stall", stall, 0);
    chk("br_flush", flush, 1);
    step();
    drive(1, 6, 0, 0, 9, 0, 0, 0);
    #1;
    chk("br_cnt", stall_cnt, FWD ? 0 : 2);
    chk("br_bubble_stall", stall, 0);
    chk("br_bubble_fwd1", fwd_sel1, 0);
    chk("br_flush_off", flush, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step(); step(); step();

    // lw r5 then add r6,r5,r5
    drive(1, 1, 2, 1, 5, 1, 1, 0);
    step();
    drive(1, 5, 5, 1, 6, 1, 0, 0);
    #1;
    chk("lu_c1_stall", stall, 1);
    step();
    #1;
    chk("lu_c2_stall", stall, FWD ? 0 : 1);
    chk("lu_c2_fwd1", fwd_sel1, FWD ? 2 : 0);
    chk("lu_c2_fwd2", fwd_sel2, FWD ? 2 : 0);
    step();
    #1;
    chk("lu_c3_stall", stall, 0);
    chk("lu_cnt", stall_cnt, FWD ? 1 : 4);
    step();

    // add r7 then a consumer of r7 (src2 unused)
    drive(1, 1, 2, 1, 7, 1, 0, 0);
    step();
    drive(1, 7, 7, 0, 9, 0, 0, 0);
    #1;
    chk("alu_stall", stall, FWD ? 0 : 1);
    chk("alu_fwd1", fwd_sel1, FWD ? 1 : 0);
    chk("alu_fwd2_unused", fwd_sel2, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step(); step(); step();

    // Counter saturation from a fresh reset: 20 stall cycles into 4 bits
    rst = 1'b0;
    #1;
    chk("sat_rst_cnt", stall_cnt, 0);
    rst = 1'b1;
    for (int i = 0; i < 22 / SPS; i++) begin
      drive(1, 1, 2, 1, 3, 1, 1, 0);
      step();
      drive(1, 3, 0, 0, 9, 0, 0, 0);
      for (int j = 0; j < SPS; j++) begin
        #1;
        chk("sat_stall", stall, 1);
        step();
      end
      if ((i + 1) * SPS == 14) chk("sat_cnt14", stall_cnt, 14);
      if ((i + 1) * SPS == 20) chk("sat_cnt20", stall_cnt, 15);
    end
    chk("sat_cnt22", stall_cnt, 15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised hazard unit for the pipelined MIPS core.
- Tracks every in-flight register write from EXE through WB in a STAGES-deep shift register.
- Stalls decode on read-after-write hazards and squashes the decode slot on a taken branch.
- Keeps a saturating stall counter; with forwarding compiled in, it stalls only on load-use and drives operand forward selects.

Parameters:
- REG_AW, 5, register address width.
- STAGES, 3, pipeline slots after ID that can hold a pending write (EXE, MEM, WB); minimum 2.
- WB_BYPASS, 1, 1 = register file writes before it reads in the same cycle, so the oldest slot never causes a hazard.
- CNT_W, 16, width of the stall counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- id_valid  in  1  decode stage holds a real instruction.
- id_src1  in  REG_AW  first source register.
- id_src2  in  REG_AW  second source register.
- id_src2_used  in  1  instruction reads src2 (0 for immediate forms).
- id_dest  in  REG_AW  destination register.
- id_wb_en  in  1  instruction writes the register file.
- id_mem_r_en  in  1  instruction is a load.
- branch_taken  in  1  EXE resolved a taken branch this cycle.
- stall  out  1  freeze PC and IF/ID register; ID/EX receives a bubble.
- flush  out  1  clear the IF/ID register; equals branch_taken.
- fwd_sel1  out  $clog2(STAGES+1)  0 = register file, k = slot k-1.
- fwd_sel2  out  $clog2(STAGES+1)  same encoding for src2.
- stall_cnt  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Slot entry: {v, wb, ld, dest}. slot[0] holds the instruction now in EXE; slot[STAGES-1] holds WB.
- Reset (rst=0, asynchronous):
  - all slots are cleared (v=0) and stall_cnt=0.
  - stall, flush and fwd_sel* are combinational and read 0 while in reset.
- Match k for source s:
  - slot[k].v & slot[k].wb & slot[k].dest!=0 & slot[k].dest==s.
  - For src2, id_src2_used must also be 1.
  - With WB_BYPASS=1, slot STAGES-1 is excluded.
- Register 0 never matches.
- stall is combinational: id_valid & hazard & !branch_taken.
- Every rising edge, slot[k] <= slot[k-1] for k>=1 (no hold; downstream stages never stall).
- slot[0] loads {1, id_wb_en, id_mem_r_en, id_dest} when id_valid & !stall & !branch_taken. Otherwise it loads a bubble (v=0).
- branch_taken has priority over stall in the same cycle:
  - the decode slot is squashed and flush=1;
  - stall=0, and stall_cnt does not increment.
- stall_cnt increments on each cycle with stall=1 and saturates at all-ones.
- Latency: a write enters slot[0] one edge after decode accepts it and leaves the scoreboard STAGES edges after that.
- Without FORWARDING_EN:
  - hazard = any match on src1 or src2;
  - fwd_sel1 and fwd_sel2 are tied to 0.
- A RAW hazard clears once the producer passes the last tracked slot.

Optional Feature:
- Macro: HAZARD_SCOREBOARD_FORWARDING_EN.
- Defined:
  - hazard = load-use only: a match in slot[0] with slot[0].ld=1.
  - fwd_selN = 1 + index of the youngest (lowest k) matching slot, else 0.
  - A younger match overrides an older one.
  - While stall=1, fwd_sel is still driven but the consumer ignores it.
- Undefined: full-stall behaviour as above.

Decomposition:
- Package mips_pkg holds:
  - REG_AW default and the slot entry typedef (v, wb, ld, dest);
  - FWD_RF constant = 0.
- One natural sub-module, hazard_match: a combinational per-source comparator that returns a match vector and youngest index. It is instantiated twice (src1, src2).
- Shift register, stall logic and counter stay in the top.

Test Plan:
- Reset held low with id_valid=1 -> stall=0, fwd_sel=0, stall_cnt=0. After release, all slots empty.
- Full-stall build, STAGES=3, WB_BYPASS=1:
  - stimulus: "add r3" decoded, then "sub r4,r3,r1".
  - response: stall=1 for exactly 2 cycles (slot0, slot1), released on the 3rd; stall_cnt=2.
- Dependency on r0:
  - stimulus: producer writes r0, consumer reads r0.
  - response: stall=0 and fwd_sel=0 throughout.
- Branch during stall:
  - stimulus: branch_taken=1 while a RAW hazard is present.
  - response: stall=0, flush=1, slot[0] bubble next cycle, stall_cnt unchanged.
- FORWARDING_EN, STAGES=3:
  - stimulus: "lw r5" then "add r6,r5,r5".
  - response: one stall cycle, then fwd_sel1=fwd_sel2=2.
  - stimulus: "add r7" then a consumer of r7.
  - response: no stall, fwd_sel1=1.
- Counter saturation, CNT_W=4:
  - stimulus: continuous hazard with a producer recycled every cycle for 20 stall cycles.
  - response: stall_cnt sticks at 15.
